// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ
// requesters, with a one-register-per-cycle clear sequencer.
module regfile_write_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 32,
   parameter int unsigned NREG = 8,
   parameter int unsigned AW   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic              clear_start,
   output logic [NREQ-1:0]   ack,
   output logic [NREG-1:0]   en,
   output logic [DW-1:0]     d_in,
   output logic [2:0]        grant_id,
   output logic              busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [AW-1:0]   cnt, cnt_nxt;
   logic [NREG-1:0] en_nxt;
   logic [DW-1:0]   d_nxt;
   logic [2:0]      gid_nxt;
   logic            busy_nxt;

   logic            found;
   logic [PW-1:0]   win;
   int unsigned     idx;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;

   // Search requesters starting at ptr; first active one wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   assign win_addr = req_addr[32'(win)*AW +: AW];
   assign win_data = req_data[32'(win)*DW +: DW];

   // Combinational acknowledge of the winner; suppressed by reset, clear start and CLEAR.
   always_comb begin
      ack = '0;
      if (!reset && (state == IDLE) && !clear_start && found) begin
         ack[win] = 1'b1;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      en_nxt    = '0;
      d_nxt     = d_in;
      gid_nxt   = grant_id;
      busy_nxt  = busy;
      unique case (state)
         IDLE: begin
            if (clear_start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
            end else if (found) begin
               // Out-of-range addresses match no enable bit, so the write is dropped.
               for (int unsigned r = 0; r < NREG; r++) begin
                  en_nxt[r] = (32'(win_addr) == r);
               end
               d_nxt   = win_data;
               gid_nxt = 3'(win);
               ptr_nxt = PW'((32'(win) + 1) % NREQ);
            end
         end
         CLEAR: begin
            for (int unsigned r = 0; r < NREG; r++) begin
               en_nxt[r] = (32'(cnt) == r);
            end
            d_nxt   = '0;
            cnt_nxt = cnt + 1'b1;
            if (cnt == AW'(NREG - 1)) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         en       <= '0;
         d_in     <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         en       <= en_nxt;
         d_in     <= d_nxt;
         grant_id <= gid_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (main instance NREG=8, second NREG=6).
module tb_regfile_write_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req;
   logic [11:0]  req_addr;
   logic [127:0] req_data;
   logic         clear_start;
   logic [3:0]   ack;
   logic [7:0]   en;
   logic [31:0]  d_in;
   logic [2:0]   grant_id;
   logic         busy;

   logic [3:0]   req2;
   logic [11:0]  req_addr2;
   logic [127:0] req_data2;
   logic [3:0]   ack2;
   logic [5:0]   en2;
   logic [31:0]  d_in2;
   logic [2:0]   grant_id2;
   logic         busy2;

   int total = 0;
   int bad   = 0;

   regfile_write_arbiter #(.NREQ(4), .DW(32), .NREG(8), .AW(3)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
      .clear_start(clear_start), .ack(ack), .en(en), .d_in(d_in),
      .grant_id(grant_id), .busy(busy));

   regfile_write_arbiter #(.NREQ(4), .DW(32), .NREG(6), .AW(3)) dut6 (
      .clk(clk), .reset(reset), .req(req2), .req_addr(req_addr2), .req_data(req_data2),
      .clear_start(1'b0), .ack(ack2), .en(en2), .d_in(d_in2),
      .grant_id(grant_id2), .busy(busy2));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111; clear_start = 1'b0;
      step();
      step();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
      total++; if (en !== 8'h00) begin bad++; $display("FAIL reset_en got=%h exp=00", en); end
      total++; if (d_in !== 32'h0) begin bad++; $display("FAIL reset_d_in got=%h exp=0", d_in); end
      total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      req = 4'b0000;
      reset = 1'b0;
      step();
   endtask

   task automatic test_single();
      req_addr[2:0] = 3'd3; req_data[31:0] = 32'hFF3F0000; req = 4'b0001;
      #1;
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b exp=0001", ack); end
      step();
      req = 4'b0000;
      total++; if (en !== 8'h08) begin bad++; $display("FAIL single_en got=%h exp=08", en); end
      total++; if (d_in !== 32'hFF3F0000) begin bad++; $display("FAIL single_d_in got=%h exp=ff3f0000", d_in); end
      total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
      #1;
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_ack_idle got=%b exp=0000", ack); end
      step();
      total++; if (en !== 8'h00) begin bad++; $display("FAIL single_en_off got=%h exp=00", en); end
      total++; if (d_in !== 32'hFF3F0000) begin bad++; $display("FAIL single_d_in_hold got=%h exp=ff3f0000", d_in); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_ack;
      logic [7:0] exp_en;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_addr[i*3 +: 3]  = 3'(i);
         req_data[i*32 +: 32] = 32'hA0 + 32'(i);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_ack = 4'b0001 << (k % 4);
         exp_en  = 8'h01 << (k % 4);
         #1;
         total++; if (ack !== exp_ack) begin bad++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", k, ack, exp_ack); end
         step();
         total++; if (en !== exp_en) begin bad++; $display("FAIL b2b_en[%0d] got=%h exp=%h", k, en, exp_en); end
         total++; if (d_in !== 32'hA0 + 32'(k % 4)) begin bad++; $display("FAIL b2b_d_in[%0d] got=%h exp=%h", k, d_in, 32'hA0 + 32'(k % 4)); end
         total++; if (grant_id !== 3'(k % 4)) begin bad++; $display("FAIL b2b_gid[%0d] got=%0d exp=%0d", k, grant_id, k % 4); end
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_wrap();
      // ptr is 1 here; granting requester 2 moves it to 3.
      req = 4'b0100;
      #1;
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL wrap_ack2 got=%b exp=0100", ack); end
      step();
      req = 4'b0101;
      #1;
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL wrap_ack0 got=%b exp=0001", ack); end
      step();
      total++; if (en !== 8'h01 || grant_id !== 3'd0) begin bad++; $display("FAIL wrap_grant0 got en=%h gid=%0d exp en=01 gid=0", en, grant_id); end
      #1;
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL wrap_ack_next got=%b exp=0100", ack); end
      step();
      req = 4'b0000;
      total++; if (en !== 8'h04 || grant_id !== 3'd2) begin bad++; $display("FAIL wrap_grant2 got en=%h gid=%0d exp en=04 gid=2", en, grant_id); end
      step();
   endtask

   task automatic test_clear();
      logic [7:0] exp_en;
      req = 4'b0010; clear_start = 1'b1;
      #1;
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL clr_start_ack got=%b exp=0000", ack); end
      step();
      clear_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         clear_start = (k == 4);
         #1;
         total++; if (ack !== 4'b0000) begin bad++; $display("FAIL clr_ack[%0d] got=%b exp=0000", k, ack); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy[%0d] got=%b exp=1", k, busy); end
         step();
         clear_start = 1'b0;
         exp_en = 8'h01 << k;
         total++; if (en !== exp_en) begin bad++; $display("FAIL clr_en[%0d] got=%h exp=%h", k, en, exp_en); end
         total++; if (d_in !== 32'h0) begin bad++; $display("FAIL clr_d_in[%0d] got=%h exp=0", k, d_in); end
      end
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy_end got=%b exp=0", busy); end
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL clr_resume_ack got=%b exp=0010", ack); end
      step();
      req = 4'b0000;
      total++; if (en !== 8'h02 || d_in !== 32'hA1 || grant_id !== 3'd1) begin
         bad++; $display("FAIL clr_resume_wr got en=%h d=%h gid=%0d exp en=02 d=a1 gid=1", en, d_in, grant_id);
      end
      step();
   endtask

   task automatic test_reset_mid_clear();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      step();
      step();
      step();
      // Fourth CLEAR cycle.
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (en !== 8'h00) begin bad++; $display("FAIL midclr_en got=%h exp=00", en); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b exp=0", busy); end
      // ptr was 2 before; a reset pointer picks requester 0.
      req = 4'b0101;
      #1;
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL midclr_ack got=%b exp=0001", ack); end
      step();
      req = 4'b0000;
      total++; if (en !== 8'h01 || d_in !== 32'hA0 || grant_id !== 3'd0) begin
         bad++; $display("FAIL midclr_wr got en=%h d=%h gid=%0d exp en=01 d=a0 gid=0", en, d_in, grant_id);
      end
      step();
   endtask

   task automatic test_out_of_range();
      do_reset();
      req_addr2[2:0] = 3'd7; req_data2[31:0] = 32'h77; req2 = 4'b0001;
      #1;
      total++; if (ack2 !== 4'b0001) begin bad++; $display("FAIL oor_ack got=%b exp=0001", ack2); end
      step();
      total++; if (en2 !== 6'h00) begin bad++; $display("FAIL oor_en got=%h exp=00", en2); end
      req_addr2[5:3] = 3'd2; req_data2[63:32] = 32'h22; req2 = 4'b0011;
      #1;
      total++; if (ack2 !== 4'b0010) begin bad++; $display("FAIL oor_ptr_ack got=%b exp=0010", ack2); end
      step();
      total++; if (en2 !== 6'h04 || d_in2 !== 32'h22) begin bad++; $display("FAIL oor_next_wr got en=%h d=%h exp en=04 d=22", en2, d_in2); end
      req_addr2[2:0] = 3'd5; req_data2[31:0] = 32'h55; req2 = 4'b0001;
      #1;
      total++; if (ack2 !== 4'b0001) begin bad++; $display("FAIL oor_top_ack got=%b exp=0001", ack2); end
      step();
      req2 = 4'b0000;
      total++; if (en2 !== 6'h20 || d_in2 !== 32'h55) begin bad++; $display("FAIL oor_top_wr got en=%h d=%h exp en=20 d=55", en2, d_in2); end
   endtask

   initial begin
      reset = 1'b1; req = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
      req2 = '0; req_addr2 = '0; req_data2 = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_clear();
      test_reset_mid_clear();
      test_out_of_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
